// File: rtl/avl_aes_regfile.sv
// Avalon-MM register file and run controller for the AES core.
// Optional run watchdog enabled by defining AES_TIMEOUT_EN.
module avl_aes_regfile #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         AVL_CS,
  input  logic         AVL_READ,
  input  logic         AVL_WRITE,
  input  logic [3:0]   AVL_ADDR,
  input  logic [3:0]   AVL_BYTE_EN,
  input  logic [31:0]  AVL_WRITEDATA,
  output logic [31:0]  AVL_READDATA,
  output logic         aes_start,
  output logic [127:0] aes_key,
  output logic [127:0] aes_msg_in,
  input  logic [127:0] aes_msg_out,
  input  logic         aes_done,
  output logic [31:0]  EXPORT_DATA
);

  localparam int unsigned NREGS       = 12;
  localparam logic [3:0]  ADDR_MSG_LO = 4'd8;
  localparam logic [3:0]  ADDR_START  = 4'd14;
  localparam logic [3:0]  ADDR_STATUS = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A zero timeout would make the watchdog compare underflow.
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("avl_aes_regfile: TIMEOUT_CYCLES must be nonzero");
  end

  state_t      state_q;
  state_t      state_d;
  logic [31:0] regs_q [NREGS];
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;
  logic        aes_start_q;
  logic        start_d;
  logic        enter_run;
  logic        wr_en;
  logic        rd_en;
  logic        start_wr;
  logic        busy;
  logic        done;
  logic        timeout_hit;
  logic        timeout_q;

  // A simultaneous read and write is handled as a write only.
  assign wr_en    = AVL_CS & AVL_WRITE;
  assign rd_en    = AVL_CS & AVL_READ & ~AVL_WRITE;
  assign start_wr = wr_en & (AVL_ADDR == ADDR_START) & AVL_BYTE_EN[0];
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);

  // Next-state and registered-output decode.
  always_comb begin
    state_d   = state_q;
    start_d   = 1'b0;
    enter_run = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_wr && AVL_WRITEDATA[0]) state_d = RUN;
      end
      RUN: begin
        if (aes_done)         state_d = DONE;
        else if (timeout_hit) state_d = IDLE;
      end
      DONE: begin
        if (start_wr) state_d = AVL_WRITEDATA[0] ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
    start_d   = (state_d == RUN);
    enter_run = (state_d == RUN) && (state_q != RUN);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      aes_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      aes_start_q <= start_d;
    end
  end

  // Software writes only while IDLE; the core result lands in 8-11 on completion.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      if (wr_en && (state_q == IDLE) && (AVL_ADDR < 4'(NREGS))) begin
        for (int b = 0; b < 4; b++) begin
          if (AVL_BYTE_EN[b]) regs_q[AVL_ADDR][8*b +: 8] <= AVL_WRITEDATA[8*b +: 8];
        end
      end
      if ((state_q == RUN) && aes_done) begin
        regs_q[ADDR_MSG_LO]        <= aes_msg_out[127:96];
        regs_q[ADDR_MSG_LO + 4'd1] <= aes_msg_out[95:64];
        regs_q[ADDR_MSG_LO + 4'd2] <= aes_msg_out[63:32];
        regs_q[ADDR_MSG_LO + 4'd3] <= aes_msg_out[31:0];
      end
    end
  end

  // Read data holds unless a qualified read is presented.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      if (AVL_ADDR < 4'(NREGS))         rdata_d = regs_q[AVL_ADDR];
      else if (AVL_ADDR == ADDR_START)  rdata_d = {31'd0, busy};
      else if (AVL_ADDR == ADDR_STATUS) rdata_d = {29'd0, timeout_q, busy, done};
      else                              rdata_d = '0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

`ifdef AES_TIMEOUT_EN
  localparam int unsigned CNT_W = 32;

  logic [CNT_W-1:0] run_cnt_q;

  assign timeout_hit = (state_q == RUN) && (run_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counts RUN cycles; the flag survives until the next accepted start.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      run_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (enter_run)            run_cnt_q <= '0;
      else if (state_q == RUN)  run_cnt_q <= run_cnt_q + CNT_W'(1);
      if (enter_run)                        timeout_q <= 1'b0;
      else if (timeout_hit && !aes_done)    timeout_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_q   = 1'b0;
`endif

  assign AVL_READDATA = rdata_q;
  assign aes_start    = aes_start_q;
  assign aes_key      = {regs_q[0], regs_q[1], regs_q[2], regs_q[3]};
  assign aes_msg_in   = {regs_q[4], regs_q[5], regs_q[6], regs_q[7]};
  assign EXPORT_DATA  = {regs_q[0][31:16], regs_q[3][15:0]};

endmodule

// File: tb/tb_avl_aes_regfile.sv
// Directed scoreboard bench for avl_aes_regfile; the watchdog section
// runs only when AES_TIMEOUT_EN is defined.
module tb_avl_aes_regfile;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         AVL_CS;
  logic         AVL_READ;
  logic         AVL_WRITE;
  logic [3:0]   AVL_ADDR;
  logic [3:0]   AVL_BYTE_EN;
  logic [31:0]  AVL_WRITEDATA;
  logic [31:0]  AVL_READDATA;
  logic         aes_start;
  logic [127:0] aes_key;
  logic [127:0] aes_msg_in;
  logic [127:0] aes_msg_out;
  logic         aes_done;
  logic [31:0]  EXPORT_DATA;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q [$];

  localparam logic [127:0] KEY    = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] RESULT = 128'h0123456789ABCDEF0123456789ABCDEF;

  always #5 CLK = ~CLK;

  avl_aes_regfile #(.TIMEOUT_CYCLES(16)) dut (
    .CLK(CLK), .RESET(RESET), .AVL_CS(AVL_CS), .AVL_READ(AVL_READ),
    .AVL_WRITE(AVL_WRITE), .AVL_ADDR(AVL_ADDR), .AVL_BYTE_EN(AVL_BYTE_EN),
    .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(AVL_READDATA),
    .aes_start(aes_start), .aes_key(aes_key), .aes_msg_in(aes_msg_in),
    .aes_msg_out(aes_msg_out), .aes_done(aes_done), .EXPORT_DATA(EXPORT_DATA)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be);
    @(negedge CLK);
    AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = addr; AVL_WRITEDATA = data; AVL_BYTE_EN = be;
    @(negedge CLK);
    AVL_CS = 1'b0; AVL_WRITE = 1'b0; AVL_BYTE_EN = 4'h0;
  endtask

  // Expected value is queued at issue and retired when the data is due.
  task automatic bus_read(input logic [3:0] addr, input logic [31:0] exp, input string tag);
    @(negedge CLK);
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = addr;
    exp_q.push_back(exp);
    @(negedge CLK);
    AVL_CS = 1'b0; AVL_READ = 1'b0;
    check(tag, AVL_READDATA, exp_q.pop_front());
  endtask

  task automatic core_done(input logic [127:0] result);
    @(negedge CLK);
    aes_done = 1'b1; aes_msg_out = result;
    @(negedge CLK);
    aes_done = 1'b0; aes_msg_out = '0;
  endtask

  initial begin
    RESET = 1'b1; AVL_CS = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0;
    AVL_ADDR = '0; AVL_BYTE_EN = '0; AVL_WRITEDATA = '0;
    aes_msg_out = '0; aes_done = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_start", aes_start, 0);
    check("rst_export", EXPORT_DATA, 0);
    check("rst_rdata", AVL_READDATA, 0);
    RESET = 1'b0;

    for (int a = 0; a < 16; a++) bus_read(4'(a), 32'h0, $sformatf("rst_rd%0d", a));

    // Key load; the digest is reg0 upper half with reg3 lower half.
    for (int w = 0; w < 4; w++) bus_write(4'(w), KEY[127-32*w -: 32], 4'hF);
    check("key_out", aes_key, KEY);
    check("export", EXPORT_DATA, 32'h00010E0F);

    bus_write(4'd4, 32'hAABBCCDD, 4'b0101);
    bus_read(4'd4, 32'h00BB00DD, "byte_en");
    check("msg_in", aes_msg_in, {32'h00BB00DD, 96'h0});

    bus_write(4'd12, 32'hFFFFFFFF, 4'hF);
    bus_read(4'd12, 32'h0, "reserved");
    bus_write(4'd15, 32'hFFFFFFFF, 4'hF);
    bus_read(4'd15, 32'h0, "status_ro");
    bus_write(4'd8, 32'h00000055, 4'hF);
    bus_read(4'd8, 32'h00000055, "msgde_sw");
    bus_write(4'd14, 32'h0, 4'h1);
    bus_read(4'd14, 32'h0, "start_zero");

    // Read and write together: write happens, read data holds.
    bus_read(4'd0, 32'h00010203, "pre_coll");
    @(negedge CLK);
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = 4'd5;
    AVL_WRITEDATA = 32'h12345678; AVL_BYTE_EN = 4'hF;
    @(negedge CLK);
    AVL_CS = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0; AVL_BYTE_EN = 4'h0;
    check("coll_hold", AVL_READDATA, 32'h00010203);
    bus_read(4'd5, 32'h12345678, "coll_write");

    // Run, locked key, completion.
    check("idle_start", aes_start, 0);
    bus_write(4'd14, 32'h1, 4'h1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("run_start%0d", i), aes_start, 1);
      @(negedge CLK);
    end
    bus_write(4'd0, 32'hFFFFFFFF, 4'hF);
    bus_read(4'd14, 32'h1, "start_rb");
    bus_read(4'd15, 32'h2, "status_busy");
    @(negedge CLK);
    check("pre_done_start", aes_start, 1);
    aes_done = 1'b1; aes_msg_out = RESULT;
    AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = 4'd14; AVL_WRITEDATA = 32'h1; AVL_BYTE_EN = 4'h1;
    @(negedge CLK);
    aes_done = 1'b0; aes_msg_out = '0;
    AVL_CS = 1'b0; AVL_WRITE = 1'b0; AVL_BYTE_EN = 4'h0;
    check("done_start", aes_start, 0);
    for (int w = 0; w < 4; w++)
      bus_read(4'(8 + w), RESULT[127-32*w -: 32], $sformatf("result%0d", w));
    bus_read(4'd15, 32'h1, "status_done");
    bus_read(4'd14, 32'h0, "start_rb_done");
    bus_read(4'd0, 32'h00010203, "key_locked");
    check("key_locked_out", aes_key, KEY);

    core_done(128'hDEADBEEF_00000000_00000000_00000000);
    bus_read(4'd8, 32'h01234567, "done_ignored");

    // DONE -> IDLE clears DONE, then an IDLE done pulse is ignored.
    bus_write(4'd14, 32'h0, 4'h1);
    bus_read(4'd15, 32'h0, "status_idle");
    core_done(128'hDEADBEEF_00000000_00000000_00000000);
    bus_read(4'd8, 32'h01234567, "idle_done_ign");

    // Second run ending in DONE, then restart from DONE directly.
    bus_write(4'd14, 32'h1, 4'h1);
    check("run2_start", aes_start, 1);
    core_done(~RESULT);
    bus_read(4'd9, ~32'h89ABCDEF, "run2_result");
    bus_write(4'd14, 32'h1, 4'h1);
    check("rerun_start", aes_start, 1);
    bus_read(4'd15, 32'h2, "rerun_busy");

    // Asynchronous reset mid-run, checked before any clock edge.
    @(negedge CLK);
    #2 RESET = 1'b1;
    #1 check("async_rst_start", aes_start, 0);
    @(negedge CLK);
    RESET = 1'b0;
    for (int a = 0; a < 12; a++) bus_read(4'(a), 32'h0, $sformatf("rst2_rd%0d", a));
    bus_read(4'd15, 32'h0, "rst2_status");
    check("rst2_key", aes_key, 0);

`ifdef AES_TIMEOUT_EN
    bus_write(4'd8, 32'hCAFEF00D, 4'hF);
    bus_write(4'd14, 32'h1, 4'h1);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("to_run%0d", i), aes_start, 1);
      if (i < 15) @(negedge CLK);
    end
    @(negedge CLK);
    check("to_abort", aes_start, 0);
    bus_read(4'd15, 32'h4, "to_status");
    bus_read(4'd8, 32'hCAFEF00D, "to_msgde");
    bus_write(4'd14, 32'h1, 4'h1);
    bus_read(4'd15, 32'h2, "to_cleared");
`endif

    repeat (2) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
